// File: rtl/mrsp_pkg.sv
// Shared types and default sizing for the MRSP auto-increment fetch sequencer.
package mrsp_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int CNT_W_DEF  = 8;
  localparam int STEP_DEF   = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_OUT,
    S_WB,
    S_DONE
  } state_t;

endpackage

// File: rtl/mrsp_autoinc_fetch_ptr_counter.sv
// Pointer and remaining-count registers: load on start, step/decrement per consumed byte.
module mrsp_ptr_counter
  import mrsp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int STEP   = STEP_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_ptr,
  input  logic [CNT_W-1:0]  i_count,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_ptr,
  output logic              o_last
);

  localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

  logic [ADDR_W-1:0] r_ptr;
  logic [CNT_W-1:0]  r_rem;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
      r_rem <= '0;
    end else if (i_load) begin
      r_ptr <= i_ptr;
      r_rem <= i_count;
    end else if (i_advance) begin
      // Pointer wraps naturally at 2^ADDR_W; the count saturates at zero.
      r_ptr <= r_ptr + STEP_V;
      if (r_rem != '0) begin
        r_rem <= r_rem - CNT_W'(1);
      end
    end
  end

  assign o_ptr  = r_ptr;
  assign o_last = (r_rem == CNT_W'(1));

endmodule

// File: rtl/mrsp_autoinc_fetch.sv
// Fetches COUNT bytes starting at PTR_IN over a req/ack memory port, streams them out,
// then writes the advanced pointer back with a one-cycle store strobe.
module mrsp_autoinc_fetch
  import mrsp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int STEP   = STEP_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] PTR_IN,
  input  logic [CNT_W-1:0]  COUNT,
  input  logic              START,
  input  logic              ABORT,
  output logic              MEM_REQ,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic              MEM_ACK,
  input  logic [7:0]        MEM_DATA,
  output logic [7:0]        OUT_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [ADDR_W-1:0] PTR_OUT,
  output logic              PTR_STO,
  output logic              BUSY,
  output logic              DONE
);

  state_t            r_state;
  state_t            w_state_next;
  logic [7:0]        r_out_data;
  logic              w_load;
  logic              w_advance;
  logic              w_capture;
  logic [ADDR_W-1:0] w_ptr;
  logic              w_last;

  mrsp_ptr_counter #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W),
    .STEP   (STEP)
  ) u_ptr_counter (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_load    (w_load),
    .i_ptr     (PTR_IN),
    .i_count   (COUNT),
    .i_advance (w_advance),
    .o_ptr     (w_ptr),
    .o_last    (w_last)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_load       = 1'b1;
          w_state_next = (COUNT == '0) ? S_WB : S_REQ;
        end
      end
      S_REQ: begin
        if (MEM_ACK) begin
          // An abort racing the ack still consumes the address but drops the byte.
          w_advance = ABORT;
          w_capture = !ABORT;
          w_state_next = ABORT ? S_WB : S_OUT;
        end else if (ABORT) begin
          w_state_next = S_WB;
        end
      end
      S_OUT: begin
        if (OUT_READY) begin
          w_advance    = 1'b1;
          w_state_next = (ABORT || w_last) ? S_WB : S_REQ;
        end else if (ABORT) begin
          w_state_next = S_WB;
        end
      end
      S_WB:    w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_out_data <= '0;
    end else if (w_capture) begin
      r_out_data <= MEM_DATA;
    end
  end

  assign MEM_REQ   = (r_state == S_REQ);
  assign MEM_ADDR  = w_ptr;
  assign OUT_VALID = (r_state == S_OUT);
  assign OUT_DATA  = r_out_data;
  assign PTR_STO   = (r_state == S_WB);
  // The writeback bus only carries the pointer while the strobe is up.
  assign PTR_OUT   = PTR_STO ? w_ptr : '0;
  assign BUSY      = (r_state != S_IDLE);
  assign DONE      = (r_state == S_DONE);

endmodule

// File: tb/tb_mrsp_autoinc_fetch.sv
// Directed scenarios for mrsp_autoinc_fetch with a cycle-stepped memory and consumer model.
module tb_mrsp_autoinc_fetch;

  logic        CLK;
  logic        RST;
  logic [15:0] PTR_IN;
  logic [7:0]  COUNT;
  logic        START;
  logic        ABORT;
  logic        MEM_REQ;
  logic [15:0] MEM_ADDR;
  logic        MEM_ACK;
  logic [7:0]  MEM_DATA;
  logic [7:0]  OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [15:0] PTR_OUT;
  logic        PTR_STO;
  logic        BUSY;
  logic        DONE;

  mrsp_autoinc_fetch dut (
    .CLK       (CLK),
    .RST       (RST),
    .PTR_IN    (PTR_IN),
    .COUNT     (COUNT),
    .START     (START),
    .ABORT     (ABORT),
    .MEM_REQ   (MEM_REQ),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_ACK   (MEM_ACK),
    .MEM_DATA  (MEM_DATA),
    .OUT_DATA  (OUT_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .PTR_OUT   (PTR_OUT),
    .PTR_STO   (PTR_STO),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Cycle bookkeeping: cyc counts negedges; the START cycle is c0.
  int cyc = 0;
  int c0  = 0;
  int sto_cnt, done_cnt, sto_cyc, done_cyc, req_seen, nack, nout, first_valid_cyc;
  logic [15:0] sto_val;
  logic [15:0] addr_log[$];
  logic [7:0]  out_log[$];

  // Scenario hooks.
  int   ack_delay   = 0;
  int   abort_ack_n = 0;
  int   abort_req_n = 0;
  int   stall_idx   = -1;
  int   stall_len   = 0;
  int   stall_left  = 0;
  int   stall_cycles, stall_viol;
  bit   stall_active = 0;
  int   glitch_cyc  = -1;
  bit   resp_en     = 1;
  int   req_wait    = 0;
  logic [7:0] stall_data;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  task automatic step();
    @(negedge CLK);
    cyc++;
    if (PTR_STO) begin sto_cnt++; sto_val = PTR_OUT; sto_cyc = cyc; end
    if (DONE) begin done_cnt++; done_cyc = cyc; end
    if (MEM_REQ) req_seen++;
    if (OUT_VALID && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (stall_active && (OUT_DATA !== stall_data || MEM_REQ !== 1'b0 || OUT_VALID !== 1'b1))
      stall_viol++;
    START   = (cyc == glitch_cyc);
    if (cyc == glitch_cyc) begin PTR_IN = 16'hDEAD; COUNT = 8'd0; end
    ABORT   = 1'b0;
    MEM_ACK = 1'b0;
    if (!MEM_REQ) req_wait = 0;
    if (resp_en && MEM_REQ) begin
      if (req_wait >= ack_delay) begin
        MEM_ACK  = 1'b1;
        MEM_DATA = mem_byte(MEM_ADDR);
        addr_log.push_back(MEM_ADDR);
        nack++;
        if (nack == abort_ack_n) ABORT = 1'b1;
        req_wait = 0;
      end else begin
        if (nack + 1 == abort_req_n) ABORT = 1'b1;
        req_wait++;
      end
    end
    OUT_READY    = 1'b1;
    stall_active = OUT_VALID && (nout == stall_idx) && (stall_left > 0);
    if (stall_active) begin
      if (stall_left == stall_len) stall_data = OUT_DATA;
      OUT_READY = 1'b0;
      stall_left--;
      stall_cycles++;
    end
    if (OUT_VALID && OUT_READY) begin out_log.push_back(OUT_DATA); nout++; end
  endtask

  task automatic set_defaults();
    ack_delay = 1; abort_ack_n = 0; abort_req_n = 0;
    stall_idx = -1; stall_len = 0; stall_left = 0; stall_active = 0;
    glitch_cyc = -1; resp_en = 1;
  endtask

  task automatic clear_logs();
    addr_log.delete(); out_log.delete();
    sto_cnt = 0; done_cnt = 0; sto_cyc = -1; done_cyc = -1; sto_val = '0;
    req_seen = 0; nack = 0; nout = 0; first_valid_cyc = -1;
    stall_cycles = 0; stall_viol = 0; stall_left = stall_len;
  endtask

  task automatic run_xfer(input logic [15:0] p, input logic [7:0] n);
    clear_logs();
    PTR_IN = p; COUNT = n; START = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 300 && done_cnt == 0; i++) step();
    n_checks++;
    if (done_cnt !== 1) $display("FAIL xfer_done ptr=%h: done pulses %0d, required 1", p, done_cnt);
    else n_pass++;
  endtask

  task automatic test_reset();
    RST = 1'b1; PTR_IN = '0; COUNT = '0; START = 0; ABORT = 0;
    MEM_ACK = 0; MEM_DATA = '0; OUT_READY = 1;
    step(); step();
    n_checks++;
    if ({MEM_REQ, OUT_VALID, PTR_STO, BUSY, DONE, MEM_ADDR, OUT_DATA, PTR_OUT} !== 45'h0)
      $display("FAIL reset_outputs: req=%b vld=%b sto=%b busy=%b done=%b addr=%h data=%h ptr=%h, required all 0",
               MEM_REQ, OUT_VALID, PTR_STO, BUSY, DONE, MEM_ADDR, OUT_DATA, PTR_OUT);
    else n_pass++;
    RST = 1'b0;
    step();
    $display("reset: outputs idle");
  endtask

  task automatic test_basic();
    set_defaults();
    run_xfer(16'h1234, 8'd3);
    for (int i = 0; i < 3; i++) begin
      logic [15:0] ea;
      ea = 16'h1234 + 16'(i);
      n_checks++;
      if (addr_log.size() <= i || addr_log[i] !== ea)
        $display("FAIL basic_addr%0d: got %h, required %h", i, (addr_log.size() > i) ? addr_log[i] : 16'hxxxx, ea);
      else n_pass++;
      n_checks++;
      if (out_log.size() <= i || out_log[i] !== mem_byte(ea))
        $display("FAIL basic_data%0d: got %h, required %h", i, (out_log.size() > i) ? out_log[i] : 8'hxx, mem_byte(ea));
      else n_pass++;
    end
    n_checks++;
    if (sto_cnt !== 1 || sto_val !== 16'h1237)
      $display("FAIL basic_wb: %0d strobes ptr=%h, required 1 strobe ptr=1237", sto_cnt, sto_val);
    else n_pass++;
    n_checks++;
    if (done_cyc !== sto_cyc + 1)
      $display("FAIL basic_done_timing: done at %0d, required %0d", done_cyc, sto_cyc + 1);
    else n_pass++;
    n_checks++;
    if (BUSY !== 1'b1) $display("FAIL basic_busy_in_done: busy=%b, required 1", BUSY);
    else n_pass++;
    step();
    n_checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0)
      $display("FAIL basic_idle_after: busy=%b done=%b, required 0 0", BUSY, DONE);
    else n_pass++;
    $display("basic: ptr=1234 count=3 wb=%h bytes=%0d", sto_val, out_log.size());
  endtask

  task automatic test_wrap();
    set_defaults();
    ack_delay = 0;
    run_xfer(16'hFFFE, 8'd4);
    n_checks++;
    if (addr_log.size() != 4 || addr_log[0] !== 16'hFFFE || addr_log[1] !== 16'hFFFF ||
        addr_log[2] !== 16'h0000 || addr_log[3] !== 16'h0001)
      $display("FAIL wrap_addrs: got %p, required FFFE FFFF 0000 0001", addr_log);
    else n_pass++;
    n_checks++;
    if (sto_val !== 16'h0002) $display("FAIL wrap_wb: got %h, required 0002", sto_val);
    else n_pass++;
    n_checks++;
    if (first_valid_cyc - c0 !== 2)
      $display("FAIL wrap_latency: first valid %0d cycles after START, required 2", first_valid_cyc - c0);
    else n_pass++;
    step();
    $display("wrap: ptr=FFFE count=4 wb=%h", sto_val);
  endtask

  task automatic test_count_zero();
    set_defaults();
    run_xfer(16'h00A5, 8'd0);
    n_checks++;
    if (req_seen !== 0) $display("FAIL zero_no_req: %0d req cycles, required 0", req_seen);
    else n_pass++;
    n_checks++;
    if (sto_val !== 16'h00A5 || sto_cyc - c0 !== 1)
      $display("FAIL zero_wb: ptr=%h at +%0d, required 00A5 at +1", sto_val, sto_cyc - c0);
    else n_pass++;
    n_checks++;
    if (done_cyc - c0 !== 2) $display("FAIL zero_done: at +%0d, required +2", done_cyc - c0);
    else n_pass++;
    step();
    $display("count0: wb=%h", sto_val);
  endtask

  task automatic test_stall();
    set_defaults();
    ack_delay = 0; stall_idx = 1; stall_len = 5;
    run_xfer(16'h4000, 8'd3);
    n_checks++;
    if (stall_cycles !== 5 || stall_viol !== 0)
      $display("FAIL stall_hold: %0d stall cycles %0d violations, required 5 and 0", stall_cycles, stall_viol);
    else n_pass++;
    n_checks++;
    if (out_log.size() != 3 || out_log[1] !== mem_byte(16'h4001) || out_log[2] !== mem_byte(16'h4002))
      $display("FAIL stall_data: got %p, required %h %h %h", out_log,
               mem_byte(16'h4000), mem_byte(16'h4001), mem_byte(16'h4002));
    else n_pass++;
    n_checks++;
    if (sto_val !== 16'h4003) $display("FAIL stall_wb: got %h, required 4003", sto_val);
    else n_pass++;
    step();
    $display("stall: 5-cycle backpressure on byte 2, wb=%h", sto_val);
  endtask

  task automatic test_abort();
    set_defaults();
    abort_ack_n = 2;
    run_xfer(16'h0100, 8'd4);
    n_checks++;
    if (out_log.size() != 1 || out_log[0] !== mem_byte(16'h0100))
      $display("FAIL abort_ack_bytes: got %0d bytes, required 1 byte %h", out_log.size(), mem_byte(16'h0100));
    else n_pass++;
    n_checks++;
    if (sto_val !== 16'h0102) $display("FAIL abort_ack_wb: got %h, required 0102", sto_val);
    else n_pass++;
    step();
    $display("abort with ack: wb=%h", sto_val);
    set_defaults();
    abort_req_n = 2;
    run_xfer(16'h0100, 8'd4);
    n_checks++;
    if (sto_val !== 16'h0101 || addr_log.size() != 1)
      $display("FAIL abort_req_wb: got %h after %0d acks, required 0101 after 1", sto_val, addr_log.size());
    else n_pass++;
    step();
    $display("abort in req: wb=%h", sto_val);
  endtask

  task automatic test_start_ignored();
    set_defaults();
    glitch_cyc = cyc + 3;
    run_xfer(16'h2000, 8'd3);
    n_checks++;
    if (addr_log.size() != 3 || addr_log[0] !== 16'h2000 || addr_log[1] !== 16'h2001 || addr_log[2] !== 16'h2002)
      $display("FAIL busy_start_addrs: got %p, required 2000 2001 2002", addr_log);
    else n_pass++;
    n_checks++;
    if (sto_val !== 16'h2003) $display("FAIL busy_start_wb: got %h, required 2003", sto_val);
    else n_pass++;
    step();
    $display("start while busy: wb=%h", sto_val);
  endtask

  task automatic test_reset_mid();
    set_defaults();
    ack_delay = 0; stall_idx = 0; stall_len = 50;
    clear_logs();
    PTR_IN = 16'h3000; COUNT = 8'd3; START = 1'b1;
    for (int i = 0; i < 20 && !OUT_VALID; i++) step();
    n_checks++;
    if (OUT_VALID !== 1'b1) $display("FAIL rst_reach_out: valid=%b, required 1", OUT_VALID);
    else n_pass++;
    stall_idx = -1; stall_active = 0; resp_en = 0;
    RST = 1'b1;
    step();
    RST = 1'b0;
    MEM_ACK = 1'b1; MEM_DATA = 8'hEE;
    step();
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if ({MEM_REQ, OUT_VALID, PTR_STO, BUSY, DONE, MEM_ADDR, OUT_DATA, PTR_OUT} !== 45'h0)
      $display("FAIL rst_mid_outputs: req=%b vld=%b sto=%b busy=%b done=%b addr=%h data=%h ptr=%h, required all 0",
               MEM_REQ, OUT_VALID, PTR_STO, BUSY, DONE, MEM_ADDR, OUT_DATA, PTR_OUT);
    else n_pass++;
    n_checks++;
    if (sto_cnt !== 0 || done_cnt !== 0)
      $display("FAIL rst_mid_no_wb: %0d strobes %0d done, required 0 0", sto_cnt, done_cnt);
    else n_pass++;
    $display("reset mid-transfer: abandoned");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_count_zero();
    test_stall();
    test_abort();
    test_start_ignored();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mrsp_autoinc_fetch.md
Name: mrsp_autoinc_fetch

Overview:
- Downstream sequencer for the MRSP pointer register. It takes the 16-bit pointer (HI_LO) and fetches a run of bytes from byte-wide memory through a req/ack handshake.
- Each fetched byte is presented on a valid/ready output stream.
- On completion or abort, the advanced pointer is written back into the pointer register through its full-word load path (A_IN / STO_A).

Parameters:
- ADDR_W, 16, pointer and memory address width
- CNT_W, 8, transfer length counter width
- STEP, 1, pointer increment per byte, added modulo 2^ADDR_W

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous active-high reset
- PTR_IN  in  ADDR_W  current pointer, from register HI_LO
- COUNT  in  CNT_W  number of bytes to fetch, sampled at START
- START  in  1  begin a transfer; honoured only in IDLE
- ABORT  in  1  end the transfer early with pointer writeback
- MEM_REQ  out  1  memory read request
- MEM_ADDR  out  ADDR_W  read address, stable while MEM_REQ=1
- MEM_ACK  in  1  read data valid this cycle
- MEM_DATA  in  8  read byte
- OUT_DATA  out  8  fetched byte
- OUT_VALID  out  1  OUT_DATA valid
- OUT_READY  in  1  consumer accepts OUT_DATA
- PTR_OUT  out  ADDR_W  pointer value to write back (to A_IN)
- PTR_STO  out  1  one-cycle store strobe (to STO_A)
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle completion pulse

Behaviour:
- Interface: one clock (CLK); synchronous active-high reset (RST).
- Reset: state=IDLE. MEM_REQ, OUT_VALID, PTR_STO, BUSY and DONE are 0. MEM_ADDR, OUT_DATA and PTR_OUT are 0. Internal ptr and remaining count are 0.
- RST asserted mid-transfer: abandons the transfer with no writeback and no DONE. A late MEM_ACK arriving after reset is ignored.
- IDLE:
  - START=1 latches ptr<=PTR_IN and rem<=COUNT.
  - If COUNT=0, go to WB. Otherwise go to REQ.
  - START in any other state is ignored.
- REQ:
  - MEM_REQ=1 and MEM_ADDR=ptr, held until MEM_ACK.
  - On MEM_ACK: capture MEM_DATA into OUT_DATA and go to OUT. MEM_REQ drops in the next cycle.
  - Minimum latency is START to first OUT_VALID = 2 cycles with ACK in the first REQ cycle.
- OUT:
  - OUT_VALID=1 and OUT_DATA held stable until OUT_READY.
  - On handshake: ptr<=ptr+STEP (wraps 0xFFFF->0x0000), rem<=rem-1.
  - If rem was 1, go to WB. Otherwise go to REQ; the next MEM_REQ follows in the following cycle.
- WB: PTR_STO=1 for exactly one cycle with PTR_OUT=ptr, then go to DONE.
- DONE: DONE=1 for one cycle, then return to IDLE. BUSY=0 in the cycle after DONE.
- ABORT, sampled only in REQ or OUT:
  - REQ without MEM_ACK: drop MEM_REQ and go to WB; ptr is unchanged.
  - REQ with MEM_ACK in the same cycle: the byte is discarded (no OUT_VALID), ptr advances by STEP, go to WB.
  - OUT with OUT_READY in the same cycle: the handshake completes and ptr advances, then go to WB.
  - OUT without OUT_READY: the byte is dropped, ptr is unchanged, go to WB.
  - ABORT is ignored in IDLE, WB and DONE.
- rem never underflows. COUNT=0 produces WB (writes back PTR_IN unchanged) then DONE, with no memory traffic.

Decomposition:
- Shared package mrsp_pkg holds:
  - state enum {IDLE, REQ, OUT, WB, DONE}
  - ADDR_W and CNT_W defaults
  - STEP constant
- One natural sub-module: mrsp_ptr_counter, the ptr/rem registers with load, step and decrement controls. The FSM stays in the top module.

Test Plan:
- PTR_IN=0x1234, COUNT=3, ACK one cycle after each REQ, OUT_READY=1 → MEM_ADDR 0x1234, 0x1235, 0x1236; three OUT bytes equal to memory contents; PTR_STO pulse with PTR_OUT=0x1237; DONE one cycle later.
- PTR_IN=0xFFFE, COUNT=4 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001; writeback 0x0002.
- COUNT=0 with PTR_IN=0x00A5 → no MEM_REQ; PTR_STO with PTR_OUT=0x00A5 on cycle 2, DONE on cycle 3.
- OUT_READY held low 5 cycles on byte 2 → OUT_DATA stable and no new MEM_REQ during the stall; transfer resumes on release.
- ABORT in the same cycle as MEM_ACK on byte 2 of 4 (PTR_IN=0x0100) → byte 2 not presented; writeback 0x0102; DONE. Separately, ABORT in REQ without ACK → writeback 0x0101.
- RST asserted during OUT, START pulsed during BUSY → after reset all outputs are 0 and no PTR_STO or DONE appears; a mid-transfer START has no effect on the address sequence.
